wave_sched_ctrl: RTL

Per-SIMD wavefront sequencer that drives the SIMD's program counter block.
- Accepts one wave at a time from the dispatcher over a valid/ready handshake.
- Clears the PC, then loops fetch -> execute -> PC advance until a halt instruction or the instruction budget is reached.
- Retires the wave with a one-cycle done pulse.
- Sits between the workgroup dispatcher, the program-memory fetch port, the SIMD execute stage and the PC.

---
 rtl/gpu_sched_pkg.sv | 27 ++
 rtl/wave_instr_budget.sv | 39 +++
 rtl/wave_sched_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gpu_sched_pkg.sv
// -----------------------------------------------------------------------------
// gpu_sched_pkg
// Shared types and default widths for the per-SIMD wavefront scheduler.
//   sched_state_e : FSM state encoding (3-bit)
//   *_DEF         : default parameter values used by wave_sched_ctrl
//   cnt_width()   : width of a counter that must hold 0..max_cnt without wrap
// -----------------------------------------------------------------------------
package gpu_sched_pkg;

  localparam int unsigned PROGRAM_MEM_ADDR_WIDTH_DEF = 32;
  localparam int unsigned WAVE_ID_WIDTH_DEF          = 4;
  localparam int unsigned MAX_INSTR_CNT_DEF          = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DISPATCH = 3'd1,
    ST_FETCH    = 3'd2,
    ST_EXEC     = 3'd3,
    ST_ADVANCE  = 3'd4,
    ST_RETIRE   = 3'd5
  } sched_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/wave_instr_budget.sv
// -----------------------------------------------------------------------------
// wave_instr_budget
// Per-wave instruction counter with budget comparator.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clear    : clear count to 0 (new wave accepted)
//   i_inc      : one non-halt instruction completed
//   o_hit_c    : combinational; the increment happening now reaches the budget
// -----------------------------------------------------------------------------
module wave_instr_budget
  import gpu_sched_pkg::*;
#(
  parameter int unsigned MAX_INSTR_CNT = MAX_INSTR_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_hit_c
);

  localparam int unsigned CNT_W = cnt_width(MAX_INSTR_CNT);

  logic [CNT_W-1:0] r_count;

  // Saturating counter: the FSM retires at the budget, so saturation only guards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_W'(MAX_INSTR_CNT))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Post-increment count equals the budget.
  assign o_hit_c = (r_count == CNT_W'(MAX_INSTR_CNT - 1));

endmodule

// File: rtl/wave_sched_ctrl.sv
// -----------------------------------------------------------------------------
// wave_sched_ctrl
// Per-SIMD wavefront sequencer: accepts one wave, clears the PC, then loops
// fetch -> execute -> PC advance until HALT or the instruction budget, and
// retires the wave with a one-cycle done pulse.
//
// Ports
//   clk, rst_n                 : clock, synchronous active-low reset
//   enable                     : global run enable; low freezes the FSM
//   wave_valid/wave_id/wave_ready : dispatcher handshake
//   pc_enable                  : mirrors enable to the PC block
//   dispatch_new_wave          : pulse, PC clears to 0
//   update_pc, pc_next         : pulse, PC loads pc_next+1 (pc_next = pc_cur)
//   pc_cur                     : current PC from the PC block
//   fetch_req/fetch_addr/fetch_ack/fetch_halt : program-memory fetch port
//   exec_start/exec_done       : SIMD execute stage handshake
//   wave_done/done_wave_id/wave_timeout : retire pulse and its qualifiers
//   busy                       : high in every state except IDLE
//
// Optional build macro WAVE_SCHED_PERF_CNT_EN adds perf_cycles/perf_instrs.
// Handshake outputs are decoded from the state register in the same cycle
// because the PC and fetch interfaces expect same-cycle response.
// -----------------------------------------------------------------------------
module wave_sched_ctrl
  import gpu_sched_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_WIDTH = PROGRAM_MEM_ADDR_WIDTH_DEF,
  parameter int unsigned WAVE_ID_WIDTH          = WAVE_ID_WIDTH_DEF,
  parameter int unsigned MAX_INSTR_CNT          = MAX_INSTR_CNT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              wave_valid,
  input  logic [WAVE_ID_WIDTH-1:0]          wave_id,
  output logic                              wave_ready,
  output logic                              pc_enable,
  output logic                              dispatch_new_wave,
  output logic                              update_pc,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_next,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_cur,
  output logic                              fetch_req,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] fetch_addr,
  input  logic                              fetch_ack,
  input  logic                              fetch_halt,
  output logic                              exec_start,
  input  logic                              exec_done,
  output logic                              wave_done,
  output logic [WAVE_ID_WIDTH-1:0]          done_wave_id,
  output logic                              wave_timeout,
  output logic                              busy
`ifdef WAVE_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_cycles,
  output logic [31:0]                       perf_instrs
`endif
);

  sched_state_e             r_state;
  sched_state_e             w_state_nxt;
  logic [WAVE_ID_WIDTH-1:0] r_wave_id;
  logic                     r_timeout;
  logic                     r_exec_issued;
  logic                     w_run;
  logic                     w_accept;
  logic                     w_adv;
  logic                     w_hit;

  // Reset low also silences the handshake so nothing is accepted or launched.
  assign w_run = enable & rst_n;

  // Instruction budget
  wave_instr_budget #(
    .MAX_INSTR_CNT (MAX_INSTR_CNT)
  ) u_budget (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept),
    .i_inc   (w_adv),
    .o_hit_c (w_hit)
  );

  // State and per-wave registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wave_id     <= '0;
      r_timeout     <= 1'b0;
      r_exec_issued <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wave_id <= wave_id;
        r_timeout <= 1'b0;
      end else if (w_adv && w_hit) begin
        r_timeout <= 1'b1;
      end
      // exec_start fires only on the first enabled EXEC cycle
      r_exec_issued <= (r_state == ST_EXEC) && (r_exec_issued || enable);
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_accept          = 1'b0;
    w_adv             = 1'b0;
    wave_ready        = 1'b0;
    dispatch_new_wave = 1'b0;
    update_pc         = 1'b0;
    fetch_req         = 1'b0;
    exec_start        = 1'b0;
    wave_done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        wave_ready = w_run;
        if (w_run && wave_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        dispatch_new_wave = w_run;
        if (w_run) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_req = w_run;
        if (w_run && fetch_ack) w_state_nxt = fetch_halt ? ST_RETIRE : ST_EXEC;
      end
      ST_EXEC: begin
        exec_start = w_run && !r_exec_issued;
        if (w_run && exec_done) w_state_nxt = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        update_pc = w_run;
        w_adv     = w_run;
        if (w_run) w_state_nxt = w_hit ? ST_RETIRE : ST_FETCH;
      end
      ST_RETIRE: begin
        wave_done = w_run;
        if (w_run) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign pc_enable    = enable;
  assign busy         = (r_state != ST_IDLE);
  assign fetch_addr   = (r_state == ST_FETCH)   ? pc_cur    : '0;
  assign pc_next      = (r_state == ST_ADVANCE) ? pc_cur    : '0;
  assign done_wave_id = (r_state == ST_RETIRE)  ? r_wave_id : '0;
  assign wave_timeout = (r_state == ST_RETIRE)  && r_timeout;

`ifdef WAVE_SCHED_PERF_CNT_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_instrs;

  // Cumulative counters, wrap at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_cycles <= '0;
      r_perf_instrs <= '0;
    end else begin
      if (enable && busy) r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_adv)          r_perf_instrs <= r_perf_instrs + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_instrs = r_perf_instrs;
`else
  // Performance counters not built.
`endif

endmodule
